// File: rtl/fsub_arbiter_if.sv
// rtl/fsub_arbiter_if.sv - requester, fsub-pipe and response bundle for fsub_arbiter
interface fsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*32-1:0] req_x1;
  logic [NREQ*32-1:0] req_x2;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        fsub_x1;
  logic [31:0]        fsub_x2;
  logic [31:0]        fsub_y;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_data;
  logic [1:0]         inflight;

  modport master (
    output req_valid, req_op, req_x1, req_x2, fsub_y,
    input  req_ready, fsub_x1, fsub_x2, resp_valid, resp_id, resp_data, inflight
  );

  modport slave (
    input  req_valid, req_op, req_x1, req_x2, fsub_y,
    output req_ready, fsub_x1, fsub_x2, resp_valid, resp_id, resp_data, inflight
  );
endinterface

// File: rtl/fsub_arbiter.sv
// rtl/fsub_arbiter.sv - round-robin sharing of one fsub pipe with id tag return
// Optional flush input enabled by FSUB_ARB_FLUSH_EN.
module fsub_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef FSUB_ARB_FLUSH_EN
  input  logic flush,
`endif
  fsub_arbiter_if.slave bus
);

  logic flush_w;
`ifdef FSUB_ARB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [IDW-1:0]  tag_id_q [LAT];
  logic [IDW-1:0]  tag_id_d [LAT];
  logic [1:0]      inflight_q, inflight_d;

  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic [31:0]     x1_sel, x2_sel;

  // Scan from rr_ptr upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (rst || flush_w) gnt_any = 1'b0;
    if (gnt_any) gnt_oh[gnt_id] = 1'b1;
  end

  // Addition is issued as x1 - (-x2).
  always_comb begin
    x1_sel = '0;
    x2_sel = '0;
    if (gnt_any) begin
      x1_sel = bus.req_x1[32*int'(gnt_id) +: 32];
      x2_sel = bus.req_x2[32*int'(gnt_id) +: 32];
      if (bus.req_op[gnt_id]) x2_sel[31] = ~x2_sel[31];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tag_vld_d  = tag_vld_q;
    tag_id_d   = tag_id_q;
    inflight_d = inflight_q;
    if (gnt_any) begin
      if (int'(gnt_id) == NREQ - 1) rr_ptr_d = '0;
      else                          rr_ptr_d = gnt_id + 1'b1;
    end
    tag_vld_d[0] = gnt_any;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    if (gnt_any && !tag_vld_q[LAT-1])      inflight_d = inflight_q + 2'd1;
    else if (!gnt_any && tag_vld_q[LAT-1]) inflight_d = inflight_q - 2'd1;
    // Results already inside the fsub are orphaned by clearing their tags.
    if (flush_w) begin
      rr_ptr_d   = '0;
      tag_vld_d  = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      inflight_q <= '0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      inflight_q <= inflight_d;
      tag_id_q   <= tag_id_d;
    end
  end

  assign bus.req_ready  = gnt_oh;
  assign bus.fsub_x1    = x1_sel;
  assign bus.fsub_x2    = x2_sel;
  assign bus.resp_valid = tag_vld_q[LAT-1];
  assign bus.resp_id    = tag_id_q[LAT-1];
  assign bus.resp_data  = bus.fsub_y;
  assign bus.inflight   = inflight_q;

endmodule

// File: tb/tb_fsub_arbiter.sv
// tb/tb_fsub_arbiter.sv - directed bench for fsub_arbiter with a behavioural 2-stage fsub
// Flush steps are compiled only when FSUB_ARB_FLUSH_EN is defined.
module tb_fsub_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_fails;

  fsub_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  fsub_arbiter #(.NREQ(4), .IDW(2), .LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef FSUB_ARB_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] b);
    int  e;
    real m;
    real p;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    p = 1.0;
    if (e >= 127) repeat (e - 127) p = p * 2.0;
    else          repeat (127 - e) p = p / 2.0;
    return b[31] ? -(m * p) : (m * p);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Shared fsub: result registered twice, no reset.
  logic [31:0] fs_s1, fs_s2;
  always @(posedge clk) begin
    fs_s1 <= r2sp(sp2r(bus.fsub_x1) - sp2r(bus.fsub_x2));
    fs_s2 <= fs_s1;
  end
  assign bus.fsub_y = fs_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] x1, input logic [31:0] x2);
    bus.req_op[i]           = op;
    bus.req_x1[32*i +: 32]  = x1;
    bus.req_x2[32*i +: 32]  = x2;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_op    = '0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    #2;
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("reset_resp_id", 32'(bus.resp_id), 32'h0);
    check("reset_inflight", 32'(bus.inflight), 32'h0);
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
    check("idle_fsub_x1", bus.fsub_x1, 32'h0);

    // Single sub: 3.0 - 1.0 from requester 0
    set_req(0, 1'b0, 32'h40400000, 32'h3F800000);
    bus.req_valid = 4'b0001;
    #1;
    check("sub_ready", 32'(bus.req_ready), 32'h1);
    check("sub_fsub_x2", bus.fsub_x2, 32'h3F800000);
    tick();
    bus.req_valid = '0;
    #1;
    check("sub_resp_early", 32'(bus.resp_valid), 32'h0);
    check("sub_inflight", 32'(bus.inflight), 32'h1);
    tick();
    check("sub_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("sub_resp_id", 32'(bus.resp_id), 32'h0);
    check("sub_resp_data", bus.resp_data, 32'h40000000);

    // Add from requester 2: 1.0 + 1.0
    set_req(2, 1'b1, 32'h3F800000, 32'h3F800000);
    bus.req_valid = 4'b0100;
    #1;
    check("add_ready", 32'(bus.req_ready), 32'h4);
    check("add_fsub_x1", bus.fsub_x1, 32'h3F800000);
    check("add_fsub_x2", bus.fsub_x2, 32'hBF800000);
    tick();
    bus.req_valid = '0;
    tick();
    check("add_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("add_resp_id", 32'(bus.resp_id), 32'h2);
    check("add_resp_data", bus.resp_data, 32'h40000000);

    // Pointer is 3: only req 1 valid, then reqs 0 and 2 with pointer at 2
    bus.req_valid = 4'b0010;
    #1;
    check("wrap_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0101;
    #1;
    check("skip_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    check("drain_inflight", 32'(bus.inflight), 32'h0);

    // Async reset with two ops in flight (pointer is 3)
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'b0001;
    tick();
    check("pre_rst_inflight", 32'(bus.inflight), 32'h2);
    rst = 1'b1;
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_inflight", 32'(bus.inflight), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    end

    // Round robin with all requesters held valid
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      tick();
      if (c >= 1) begin
        check("rr_resp_id", 32'(bus.resp_id), 32'((c - 1) % 4));
        check("rr_resp_valid", 32'(bus.resp_valid), 32'h1);
        check("rr_inflight", 32'(bus.inflight), 32'h2);
      end
    end
    bus.req_valid = '0;
    tick();
    check("rr_last_id", 32'(bus.resp_id), 32'h3);
    check("rr_tail_inflight", 32'(bus.inflight), 32'h1);
    tick();
    check("rr_done_valid", 32'(bus.resp_valid), 32'h0);
    check("rr_done_inflight", 32'(bus.inflight), 32'h0);

`ifdef FSUB_ARB_FLUSH_EN
    // Issue from req 1, flush next cycle, next grant returns to index 0
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b1111;
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(bus.req_ready), 32'h0);
    tick();
    flush = 1'b0;
    bus.req_valid = '0;
    #1;
    check("flush_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("flush_inflight", 32'(bus.inflight), 32'h0);
    bus.req_valid = 4'b1110;
    bus.req_valid = 4'b1111;
    #1;
    check("flush_next_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
